mips_lsu_llsc: RTL and testbench

- Parametrised load/store unit for the next-generation MIPS core pipeline.
- Sits between the execute stage and a variable-latency data memory port that uses a req/gnt/rvalid handshake. This replaces the fixed single-cycle memory timing.
- Performs big-endian lane steering for byte, halfword and word accesses, and sign/zero extension of load data.
- Maintains an LL/SC reservation register that produces real SC success/failure results, with snoop invalidation and an optional response timeout.

---
 rtl/mips_lsu_llsc_if.sv | 46 ++++
 rtl/mips_lsu_llsc.sv | 209 ++++++++++++++++++++
 tb/tb_mips_lsu_llsc.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/mips_lsu_llsc_if.sv
// Bus bundle for the MIPS load/store unit.
//   req_*  : execute stage -> LSU operation handshake (valid/ready)
//   mem_*  : LSU -> data memory, req/gnt command plus rvalid read return
//   rsp_*  : LSU -> writeback completion pulse
// modport master : the LSU side (drives req_ready, mem_* commands, rsp_*)
// modport slave  : the environment side (pipeline plus memory)
interface mips_lsu_llsc_if #(parameter int ADDR_W = 32);
  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_op;
  logic [1:0]        req_size;
  logic              req_signext;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic [4:0]        req_rd;

  logic              mem_req;
  logic [3:0]        mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [31:0]       mem_rdata;

  logic              rsp_valid;
  logic              rsp_we;
  logic [4:0]        rsp_rd;
  logic [31:0]       rsp_data;
  logic              rsp_err;

  modport master (
    input  req_valid, req_op, req_size, req_signext, req_addr, req_wdata, req_rd,
    output req_ready,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output rsp_valid, rsp_we, rsp_rd, rsp_data, rsp_err
  );

  modport slave (
    output req_valid, req_op, req_size, req_signext, req_addr, req_wdata, req_rd,
    input  req_ready,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  rsp_valid, rsp_we, rsp_rd, rsp_data, rsp_err
  );
endinterface

// File: rtl/mips_lsu_llsc.sv
// MIPS load/store unit with big-endian lane steering, load extension and an
// LL/SC reservation register, talking to a variable-latency req/gnt/rvalid port.
//
// state | meaning
// IDLE  | ready for a new operation
// REQ   | mem_req held until mem_gnt
// WAIT  | load/LL granted, waiting for mem_rvalid (optional timeout)
// RESP  | one-cycle rsp_valid pulse
//
// Ports: clk, rst_n (async active-low), en (global hold), snoop_valid/snoop_addr
// (external write notification), resv_clear (exception/ERET), busy (not IDLE),
// bus (mips_lsu_llsc_if.master: req/mem/rsp groups).
module mips_lsu_llsc #(
  parameter int ADDR_W    = 32,
  parameter int RESV_GRAN = 4,
  parameter int TIMEOUT   = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              snoop_valid,
  input  logic [ADDR_W-1:0] snoop_addr,
  input  logic              resv_clear,
  output logic              busy,
  mips_lsu_llsc_if.master   bus
);
  localparam int GW    = ADDR_W - RESV_GRAN;
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [1:0] OP_LOAD = 2'd0, OP_STORE = 2'd1, OP_LL = 2'd2, OP_SC = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

  state_t           state;
  logic [1:0]       op_q, size_q, off_q;
  logic             signext_q;
  logic [GW-1:0]    gran_q;
  logic [CNT_W-1:0] cnt;
  logic             resv_valid;
  logic [GW-1:0]    resv_gran;

  function automatic logic [3:0] lane_we(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'd0:    lane_we = 4'b1000 >> off;
      2'd1:    lane_we = off[1] ? 4'b0011 : 4'b1100;
      default: lane_we = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] w);
    case (size)
      2'd0:    lane_wdata = {4{w[7:0]}};
      2'd1:    lane_wdata = {2{w[15:0]}};
      default: lane_wdata = w;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input logic [31:0] d, input logic [1:0] size,
                                           input logic [1:0] off, input logic sx);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = d[31:24];
      2'd1:    b = d[23:16];
      2'd2:    b = d[15:8];
      default: b = d[7:0];
    endcase
    h = off[1] ? d[15:0] : d[31:16];
    case (size)
      2'd0:    load_ext = {{24{sx & b[7]}}, b};
      2'd1:    load_ext = {{16{sx & h[15]}}, h};
      default: load_ext = d;
    endcase
  endfunction

  logic          misaligned, sc_ok, is_store_req;
  logic [GW-1:0] req_gran, snoop_gran;

  assign req_gran     = bus.req_addr[ADDR_W-1:RESV_GRAN];
  assign snoop_gran   = snoop_addr[ADDR_W-1:RESV_GRAN];
  assign misaligned   = (bus.req_size == 2'd3) ||
                        (bus.req_size == 2'd1 && bus.req_addr[0]) ||
                        (bus.req_size == 2'd2 && bus.req_addr[1:0] != 2'b00);
  assign sc_ok        = resv_valid && (resv_gran == req_gran);
  assign is_store_req = (bus.req_op == OP_STORE) || (bus.req_op == OP_SC);

  assign busy          = (state != S_IDLE);
  assign bus.req_ready = rst_n & en & (state == S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      op_q          <= OP_LOAD;
      size_q        <= 2'd0;
      off_q         <= 2'd0;
      signext_q     <= 1'b0;
      gran_q        <= '0;
      cnt           <= '0;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 4'b0000;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_we    <= 1'b0;
      bus.rsp_rd    <= '0;
      bus.rsp_data  <= '0;
      bus.rsp_err   <= 1'b0;
    end else if (en) begin
      case (state)
        S_IDLE: begin
          if (bus.req_valid) begin
            op_q         <= bus.req_op;
            size_q       <= bus.req_size;
            off_q        <= bus.req_addr[1:0];
            signext_q    <= bus.req_signext;
            gran_q       <= req_gran;
            bus.rsp_rd   <= bus.req_rd;
            bus.rsp_data <= '0;
            if (misaligned) begin
              state         <= S_RESP;
              bus.rsp_valid <= 1'b1;
              bus.rsp_we    <= 1'b0;
              bus.rsp_err   <= 1'b1;
            end else if (bus.req_op == OP_SC && !sc_ok) begin
              // Failed SC never touches memory.
              state         <= S_RESP;
              bus.rsp_valid <= 1'b1;
              bus.rsp_we    <= 1'b1;
              bus.rsp_err   <= 1'b0;
            end else begin
              state         <= S_REQ;
              bus.mem_req   <= 1'b1;
              bus.mem_addr  <= {bus.req_addr[ADDR_W-1:2], 2'b00};
              bus.mem_we    <= is_store_req ? lane_we(bus.req_size, bus.req_addr[1:0]) : 4'b0000;
              bus.mem_wdata <= lane_wdata(bus.req_size, bus.req_wdata);
              bus.rsp_we    <= 1'b0;
              bus.rsp_err   <= 1'b0;
            end
          end
        end
        S_REQ: begin
          if (bus.mem_gnt) begin
            bus.mem_req <= 1'b0;
            bus.mem_we  <= 4'b0000;
            if (op_q == OP_LOAD || op_q == OP_LL) begin
              state <= S_WAIT;
              cnt   <= CNT_W'(TIMEOUT);
            end else begin
              state         <= S_RESP;
              bus.rsp_valid <= 1'b1;
              bus.rsp_we    <= (op_q == OP_SC);
              bus.rsp_data  <= {31'd0, op_q == OP_SC};
            end
          end
        end
        S_WAIT: begin
          if (bus.mem_rvalid) begin
            state         <= S_RESP;
            bus.rsp_valid <= 1'b1;
            bus.rsp_we    <= 1'b1;
            bus.rsp_data  <= load_ext(bus.mem_rdata, size_q, off_q, signext_q);
          end else if (TIMEOUT > 0 && cnt == CNT_W'(1)) begin
            // Down-counter loaded with TIMEOUT at grant: terminal count after TIMEOUT WAIT cycles.
            state         <= S_RESP;
            bus.rsp_valid <= 1'b1;
            bus.rsp_err   <= 1'b1;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        S_RESP: begin
          state         <= S_IDLE;
          bus.rsp_valid <= 1'b0;
          bus.rsp_we    <= 1'b0;
          bus.rsp_err   <= 1'b0;
          bus.rsp_data  <= '0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Reservation keeps tracking snoops and resv_clear even while en=0.
  // Clearing events take priority over an LL setting it in the same cycle;
  // a snoop is compared against the granule being set in that case.
  logic          resv_set, resv_clr, snoop_hit, st_hit, sc_done;
  logic [GW-1:0] cmp_gran;

  assign resv_set  = en && state == S_RESP && op_q == OP_LL && !bus.rsp_err;
  assign sc_done   = en && state == S_RESP && op_q == OP_SC && !bus.rsp_err;
  assign st_hit    = en && state == S_REQ && op_q == OP_STORE && bus.mem_gnt && gran_q == resv_gran;
  assign cmp_gran  = resv_set ? gran_q : resv_gran;
  assign snoop_hit = snoop_valid && snoop_gran == cmp_gran;
  assign resv_clr  = sc_done || st_hit || resv_clear || snoop_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resv_valid <= 1'b0;
      resv_gran  <= '0;
    end else if (resv_clr) begin
      resv_valid <= 1'b0;
    end else if (resv_set) begin
      resv_valid <= 1'b1;
      resv_gran  <= gran_q;
    end
  end

  logic unused_snoop_lsb;
  assign unused_snoop_lsb = ^snoop_addr[RESV_GRAN-1:0];
endmodule

// File: tb/tb_mips_lsu_llsc.sv
module tb_mips_lsu_llsc;
  localparam int RG = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b1;
  logic        snoop_valid = 1'b0;
  logic [31:0] snoop_addr = '0;
  logic        resv_clear = 1'b0;
  logic        busy;

  int total = 0;
  int bad = 0;

  // Reference reservation: valid flag plus granule number (addr / 16).
  bit          m_valid = 0;
  int unsigned m_gran = 0;

  mips_lsu_llsc_if #(.ADDR_W(32)) bus ();

  mips_lsu_llsc #(.ADDR_W(32), .RESV_GRAN(RG), .TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .snoop_valid(snoop_valid),
    .snoop_addr(snoop_addr), .resv_clear(resv_clear), .busy(busy), .bus(bus.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] exp_we(input int size, input int off);
    if (size == 0) return 4'(8 >> off);
    if (size == 1) return (off < 2) ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  function automatic logic [31:0] exp_wd(input int size, input logic [31:0] w);
    if (size == 0) return (w & 32'hFF) * 32'h01010101;
    if (size == 1) return (w & 32'hFFFF) * 32'h00010001;
    return w;
  endfunction

  function automatic logic [31:0] exp_ld(input int size, input int off, input bit sx, input logic [31:0] d);
    logic [31:0] v;
    if (size == 0) begin
      v = (d >> ((3 - off) * 8)) & 32'hFF;
      if (sx && v >= 32'h80) v = v | 32'hFFFFFF00;
    end else if (size == 1) begin
      v = (d >> ((2 - (off & 2)) * 8)) & 32'hFFFF;
      if (sx && v >= 32'h8000) v = v | 32'hFFFF0000;
    end else v = d;
    return v;
  endfunction

  task automatic side_evt(input bit snp, input logic [31:0] a, input bit clr);
    @(negedge clk);
    snoop_valid = snp; snoop_addr = a; resv_clear = clr;
    @(negedge clk);
    snoop_valid = 0; resv_clear = 0;
    if (clr || (snp && m_valid && (a >> RG) == m_gran)) m_valid = 0;
  endtask

  task automatic run_op(input int op, input int size, input bit sx, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [4:0] rd, input int gnt_lat,
                        input int rv_lat, input int stall, input bit no_rv,
                        input bit snoop_rsp, input logic [31:0] snp_addr, input logic [31:0] rdata);
    bit err, is_ld, sc_pass, exp_mem, got, seen, granted, rv_done, stalling;
    int exp_k, got_k, gw, rw, stall_left;
    logic        e_we, e_err;
    logic [31:0] e_data;
    err     = (size == 3) || (size == 1 && addr[0]) || (size == 2 && addr[1:0] != 0);
    is_ld   = (op == 0 || op == 2);
    sc_pass = m_valid && (addr >> RG) == m_gran;
    exp_mem = !err && !(op == 3 && !sc_pass);
    e_data = 0; e_err = 0; e_we = 0;
    if (err) begin exp_k = 1; e_err = 1; end
    else if (op == 3 && !sc_pass) begin exp_k = 1; e_we = 1; end
    else if (is_ld && no_rv) begin exp_k = 6 + stall + gnt_lat; e_err = 1; end
    else if (is_ld) begin exp_k = 3 + stall + gnt_lat + rv_lat; e_we = 1; e_data = exp_ld(size, int'(addr[1:0]), sx, rdata); end
    else begin exp_k = 2 + stall + gnt_lat; e_we = (op == 3); e_data = (op == 3) ? 1 : 0; end

    @(negedge clk);
    chk("ready_idle", bus.req_ready, 1);
    bus.req_valid = 1; bus.req_op = 2'(op); bus.req_size = 2'(size); bus.req_signext = sx;
    bus.req_addr = addr; bus.req_wdata = wdata; bus.req_rd = rd;
    got = 0; seen = 0; granted = 0; rv_done = 0; stalling = 0;
    got_k = 0; gw = 0; rw = 0; stall_left = stall;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      bus.req_valid = 0; bus.mem_gnt = 0; bus.mem_rvalid = 0;
      if (stalling) chk("req_held_en0", bus.mem_req, 1);
      stalling = 0;
      if (bus.rsp_valid) begin
        got = 1; got_k = k;
        if (snoop_rsp) begin snoop_valid = 1; snoop_addr = snp_addr; end
        break;
      end
      if (bus.mem_req) begin
        if (!exp_mem) chk("unexpected_mem_req", bus.mem_req, 0);
        else if (!seen) begin
          seen = 1;
          chk("mem_addr", bus.mem_addr, addr & ~32'h3);
          chk("mem_we", 32'(bus.mem_we), is_ld ? 0 : 32'(exp_we(size, int'(addr[1:0]))));
          if (!is_ld) chk("mem_wdata", bus.mem_wdata, exp_wd(size, wdata));
        end
        if (stall_left > 0) begin
          en = 0; stall_left--; stalling = 1;
        end else begin
          en = 1;
          if (gw == gnt_lat) begin
            bus.mem_gnt = 1; granted = 1;
            if (op == 1 && m_valid && (addr >> RG) == m_gran) m_valid = 0;
          end else gw++;
        end
      end else if (granted && is_ld && !no_rv && !rv_done) begin
        if (rw == rv_lat) begin bus.mem_rvalid = 1; bus.mem_rdata = rdata; rv_done = 1; end
        else rw++;
      end
    end
    en = 1;
    chk("rsp_seen", 32'(got), 1);
    if (got) begin
      chk("rsp_latency", 32'(got_k), 32'(exp_k));
      chk("rsp_err", bus.rsp_err, e_err);
      chk("rsp_we", bus.rsp_we, e_we);
      chk("rsp_rd", bus.rsp_rd, rd);
      if (e_we) chk("rsp_data", bus.rsp_data, e_data);
    end
    if (!e_err && op == 2) begin m_valid = 1; m_gran = addr >> RG; end
    if (!e_err && op == 3) m_valid = 0;
    if (snoop_rsp && m_valid && (snp_addr >> RG) == m_gran) m_valid = 0;
    @(negedge clk);
    snoop_valid = 0;
    chk("rsp_one_cycle", bus.rsp_valid, 0);
    chk("idle_after", busy, 0);
  endtask

  initial begin
    bus.req_valid = 0; bus.req_op = 0; bus.req_size = 0; bus.req_signext = 0;
    bus.req_addr = 0; bus.req_wdata = 0; bus.req_rd = 0;
    bus.mem_gnt = 0; bus.mem_rvalid = 0; bus.mem_rdata = 0;

    #3;
    chk("rst_mem_req", bus.mem_req, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", bus.req_ready, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1;
    #1 chk("ready_after_rst", bus.req_ready, 1);

    // LB with sign extension, offset 3
    run_op(0, 0, 1, 32'h103, 0, 5'd7, 0, 0, 0, 0, 0, 0, 32'h123456F0);
    // SH at 0x202
    run_op(1, 1, 0, 32'h202, 32'h0000BEEF, 5'd3, 0, 0, 0, 0, 0, 0, 0);
    // misaligned LW
    run_op(0, 2, 0, 32'h101, 0, 5'd4, 0, 0, 0, 0, 0, 0, 0);
    // illegal size
    run_op(0, 3, 0, 32'h100, 0, 5'd4, 0, 0, 0, 0, 0, 0, 0);
    // LL then SC in same granule passes, second SC fails
    run_op(2, 2, 0, 32'h400, 0, 5'd8, 0, 0, 0, 0, 0, 0, 32'hCAFEF00D);
    run_op(3, 2, 0, 32'h404, 32'h11223344, 5'd9, 1, 0, 0, 0, 0, 0, 0);
    run_op(3, 2, 0, 32'h404, 32'h11223344, 5'd9, 0, 0, 0, 0, 0, 0, 0);
    // snoop in granule kills reservation; snoop in next granule does not
    run_op(2, 2, 0, 32'h400, 0, 5'd8, 0, 1, 0, 0, 0, 0, 32'h1);
    side_evt(1, 32'h40C, 0);
    run_op(3, 2, 0, 32'h400, 32'h5, 5'd9, 0, 0, 0, 0, 0, 0, 0);
    run_op(2, 2, 0, 32'h400, 0, 5'd8, 0, 0, 0, 0, 0, 0, 32'h2);
    side_evt(1, 32'h410, 0);
    run_op(3, 2, 0, 32'h400, 32'h5, 5'd9, 0, 0, 0, 0, 0, 0, 0);
    // resv_clear, local store to granule, snoop on LL response cycle
    run_op(2, 2, 0, 32'h400, 0, 5'd8, 0, 0, 0, 0, 0, 0, 32'h3);
    side_evt(0, 0, 1);
    run_op(3, 2, 0, 32'h400, 32'h5, 5'd9, 0, 0, 0, 0, 0, 0, 0);
    run_op(2, 2, 0, 32'h400, 0, 5'd8, 0, 0, 0, 0, 0, 0, 32'h4);
    run_op(1, 0, 0, 32'h40B, 32'hAB, 5'd1, 0, 0, 0, 0, 0, 0, 0);
    run_op(3, 2, 0, 32'h400, 32'h5, 5'd9, 0, 0, 0, 0, 0, 0, 0);
    run_op(2, 2, 0, 32'h400, 0, 5'd8, 0, 0, 0, 0, 1, 32'h404, 32'h6);
    run_op(3, 2, 0, 32'h400, 32'h5, 5'd9, 0, 0, 0, 0, 0, 0, 0);
    // timeout and en stall
    run_op(0, 2, 0, 32'h300, 0, 5'd2, 0, 0, 0, 1, 0, 0, 0);
    run_op(0, 1, 1, 32'h302, 0, 5'd2, 0, 0, 3, 0, 0, 0, 32'h1234F00F);
    run_op(1, 2, 0, 32'h304, 32'hDEADBEEF, 5'd2, 1, 0, 3, 0, 0, 0, 0);

    // randomized traffic against the reference model
    for (int i = 0; i < 200; i++) begin
      int op, size;
      logic [31:0] a;
      op = int'($urandom_range(0, 3));
      size = ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, 2));
      a = 32'h100 + $urandom_range(0, 63);
      if ($urandom_range(0, 3) == 0) side_evt($urandom_range(0, 1) == 1, 32'h100 + $urandom_range(0, 63), $urandom_range(0, 4) == 0);
      run_op(op, size, $urandom_range(0, 1) == 1, a, $urandom, 5'($urandom),
             int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), int'($urandom_range(0, 1)),
             0, $urandom_range(0, 5) == 0, 32'h100 + $urandom_range(0, 63), $urandom);
    end

    // reset mid-operation: load aborted, reservation lost
    run_op(2, 2, 0, 32'h500, 0, 5'd8, 0, 0, 0, 0, 0, 0, 32'h7);
    @(negedge clk);
    bus.req_valid = 1; bus.req_op = 0; bus.req_size = 2; bus.req_addr = 32'h500;
    @(negedge clk);
    bus.req_valid = 0; bus.mem_gnt = 1;
    @(negedge clk);
    bus.mem_gnt = 0;
    chk("busy_in_wait", busy, 1);
    #2 rst_n = 0;
    #1 chk("abort_busy", busy, 0);
    chk("abort_mem_req", bus.mem_req, 0);
    chk("abort_rsp_valid", bus.rsp_valid, 0);
    m_valid = 0;
    @(negedge clk);
    rst_n = 1;
    bus.mem_rvalid = 1; bus.mem_rdata = 32'h99;
    @(negedge clk);
    bus.mem_rvalid = 0;
    chk("no_rsp_after_abort", bus.rsp_valid, 0);
    run_op(3, 2, 0, 32'h500, 32'h1, 5'd9, 0, 0, 0, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
